// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the loadable instruction memory
package imem_pkg;
    typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;
    localparam logic [31:0] NOP = 32'h8b1f03ff;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: simple dual-port RAM with one write port and a registered read port
module imem_ram #(
    parameter int N      = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [N-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [N-1:0]      rdata
);
    logic [N-1:0] mem [2**ADDR_W];
    // write port, no reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // registered read port, holds its value while re is low
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/imem_prog.sv
// imem_prog: instruction memory with power-up clear, streamed programming and stallable registered fetch
module imem_prog
    import imem_pkg::*;
#(
    parameter int N      = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd_en,
    output logic [N-1:0]      q,
    output logic              valid,
    output logic              busy,
    input  logic              prog_start,
    input  logic              prog_valid,
    input  logic [N-1:0]      prog_data,
    input  logic              prog_last,
    output logic              prog_ready,
    output logic              prog_done
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              valid_q, valid_d, done_q, done_d;
    logic              accept, finish, we, re;
    logic [N-1:0]      wdata, rdata;

    assign accept = state_q == LOAD && prog_valid;
    assign finish = accept && (prog_last || &cnt_q);

    // state, address counter and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // next state; the counter wraps to zero naturally at the last word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        done_d  = finish;
        case (state_q)
            CLEAR: begin
                state_d = &cnt_q ? RUN : CLEAR;
                cnt_d   = cnt_q + ADDR_W'(1);
            end
            RUN: begin
                state_d = prog_start ? LOAD : RUN;
                cnt_d   = '0;
                valid_d = !prog_start && (rd_en || valid_q);
            end
            LOAD: begin
                state_d = finish ? RUN : LOAD;
                cnt_d   = finish ? '0 : cnt_q + ADDR_W'(accept);
            end
            default: state_d = CLEAR;
        endcase
    end

    // handshake outputs and RAM port control
    always_comb begin
        busy       = state_q != RUN;
        prog_ready = state_q == LOAD;
        we         = state_q == CLEAR || accept;
        re         = state_q == RUN && rd_en && !prog_start;
        wdata      = state_q == CLEAR ? '0 : prog_data;
    end

    // q is forced to zero whenever no fetch result is valid, so the RAM output needs no reset
    assign q         = valid_q ? rdata : '0;
    assign valid     = valid_q;
    assign prog_done = done_q;

    imem_ram #(.N(N), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (cnt_q),
        .wdata (wdata),
        .re    (re),
        .raddr (addr),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_imem_prog.sv
// tb_imem_prog: scoreboard bench for the loadable instruction memory
module tb_imem_prog;
    import imem_pkg::*;
    logic        clk = 1'b0, reset = 1'b1, rd_en = 1'b0, prog_start = 1'b0;
    logic        prog_valid = 1'b0, prog_last = 1'b0;
    logic [6:0]  addr = '0;
    logic [31:0] prog_data = NOP;
    logic [31:0] q;
    logic        valid, busy, prog_ready, prog_done;
    int          checks = 0, errors = 0, done_cnt = 0, wcnt = 0, d0;
    logic [31:0] ref_mem [128];
    logic [31:0] exp_q [$];
    logic [31:0] prog1 [9] = '{32'hf8000001, 32'hf8008002, 32'h8b050083, 32'h8b0800a4,
                               32'hf8400006, 32'h8b0800c7, 32'h8b030041, 32'h8b0a0122,
                               32'hb400001f};

    always #5 clk = ~clk;

    imem_prog dut (
        .clk(clk), .reset(reset), .addr(addr), .rd_en(rd_en), .q(q), .valid(valid),
        .busy(busy), .prog_start(prog_start), .prog_valid(prog_valid),
        .prog_data(prog_data), .prog_last(prog_last), .prog_ready(prog_ready),
        .prog_done(prog_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (prog_done === 1'b1) done_cnt++;
    end

    initial begin
        logic s;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            s = rd_en;
            #1;
            if (s && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rd_q", q, e);
                check("rd_valid", {31'b0, valid}, 32'd1);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        int n;
        @(negedge clk);
        reset = 1'b1; rd_en = 1'b0; prog_start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_q", q, 32'd0);
        check("rst_ready", {31'b0, prog_ready}, 32'd0);
        check("rst_done", {31'b0, prog_done}, 32'd0);
        reset = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("clear_len", n, 32'd128);
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    endtask

    task automatic rd(input logic [6:0] a);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        exp_q.push_back(ref_mem[a]);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic start();
        @(negedge clk);
        prog_start = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        prog_start = 1'b0; rd_en = 1'b0;
        wcnt = 0;
        check("load_ready", {31'b0, prog_ready}, 32'd1);
        check("load_busy", {31'b0, busy}, 32'd1);
        check("load_valid", {31'b0, valid}, 32'd0);
        check("load_q", q, 32'd0);
    endtask

    task automatic word(input logic [31:0] d, input logic v, input logic l);
        prog_valid = v; prog_data = d; prog_last = l;
        if (v) begin
            ref_mem[wcnt] = d;
            wcnt++;
        end
        @(negedge clk);
        prog_valid = 1'b0; prog_last = 1'b0; prog_data = NOP;
    endtask

    task automatic done_chk(input int base);
        check("done_pulse", {31'b0, prog_done}, 32'd1);
        check("done_ready", {31'b0, prog_ready}, 32'd0);
        check("done_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("done_low", {31'b0, prog_done}, 32'd0);
        check("done_once", done_cnt - base, 32'd1);
    endtask

    initial begin
        do_reset();
        rd(7'd5);
        check("q_before_reread", q, 32'd0);

        d0 = done_cnt;
        start();
        for (int i = 0; i < 9; i++) word(prog1[i], 1'b1, i == 8);
        done_chk(d0);
        for (int i = 0; i < 10; i++) rd(7'(i));

        rd(7'd1);
        for (int a = 2; a <= 4; a++) begin
            addr = 7'(a);
            @(negedge clk);
            check("stall_q", q, 32'hf8008002);
            check("stall_valid", {31'b0, valid}, 32'd1);
        end
        rd(7'd4);

        d0 = done_cnt;
        start();
        word(32'haaaa0001, 1'b1, 1'b0);
        word(32'hdeadbeef, 1'b0, 1'b0);
        word(32'hdeadbeef, 1'b0, 1'b0);
        word(32'hbbbb0002, 1'b1, 1'b0);
        word(32'hcccc0003, 1'b1, 1'b1);
        done_chk(d0);
        for (int i = 0; i < 5; i++) rd(7'(i));

        d0 = done_cnt;
        start();
        for (int i = 0; i < 128; i++) word(32'(i), 1'b1, 1'b0);
        done_chk(d0);
        rd(7'd127);
        rd(7'd0);
        rd(7'd64);

        d0 = done_cnt;
        start();
        for (int i = 0; i < 3; i++) word(32'h5a5a0000 + 32'(i), 1'b1, 1'b0);
        do_reset();
        check("midload_no_done", done_cnt - d0, 32'd0);
        rd(7'd0);
        rd(7'd127);

        @(negedge clk);
        @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
